fx3_burst_reader: RTL and testbench

Downstream consumer of the dual-clock sample FIFO: reads 16-bit RF samples from the FIFO's show-ahead read port and presents them to the Cypress FX3 GPIF bus in fixed-length bursts. It runs entirely in the FIFO read-clock domain and uses the FIFO's registered level flags for flow control. It also reports sticky overflow and underflow errors to the host-facing status logic.

---
 rtl/fx3_burst_reader.sv | 136 +++++++++++++
 tb/tb_fx3_burst_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_burst_reader.sv
// fx3_burst_reader
//   Drains 16-bit samples from the show-ahead read port of the sample FIFO.
//   Presents them to the FX3 GPIF bus in fixed-length bursts. Everything runs
//   in the FIFO read-clock domain and is paced by the FIFO's registered flags.
//
// Ports
//   outputClock    GPIF clock (same as the FIFO read clock)
//   nReset         asynchronous active-low reset
//   collectData    capture enable; low abandons any burst and clears errors
//   fifoData       FIFO show-ahead data, valid while the FIFO is not empty
//   empty_flag     registered FIFO empty flag
//   halfFull_flag  registered FIFO half-full flag
//   full_flag      registered FIFO full flag
//   fifoAck        FIFO read acknowledge; consumes one word per high cycle
//   fx3Ready       FX3 accepts a word this cycle
//   dataOut        word to the GPIF bus
//   dataValid      dataOut carries a new word this cycle
//   dataAvailable  a full burst can be served
//   overflowError  sticky: FIFO reached full while capturing
//   underflowError sticky: FIFO ran empty mid-burst
module fx3_burst_reader #(
  parameter int BURST_WORDS = 4096,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        outputClock,
  input  logic        nReset,
  input  logic        collectData,
  input  logic [15:0] fifoData,
  input  logic        empty_flag,
  input  logic        halfFull_flag,
  input  logic        full_flag,
  output logic        fifoAck,
  input  logic        fx3Ready,
  output logic [15:0] dataOut,
  output logic        dataValid,
  output logic        dataAvailable,
  output logic        overflowError,
  output logic        underflowError
);

  localparam int CW = $clog2(BURST_WORDS) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_WORDS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, GAP} readerState_t;

  readerState_t   state, stateNext;
  logic [CW-1:0]  wordCnt, wordCntNext;
  logic [GW-1:0]  gapCnt, gapCntNext;
  logic           availNext;
  logic           ackNow;

  // State register
  always_ff @(posedge outputClock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state, counters and the combinational FIFO acknowledge
  always_comb begin
    stateNext   = state;
    wordCntNext = wordCnt;
    gapCntNext  = gapCnt;
    availNext   = 1'b0;
    ackNow      = 1'b0;
    case (state)
      IDLE: begin
        if (collectData) stateNext = WAIT;
      end
      WAIT: begin
        availNext = halfFull_flag;
        if (halfFull_flag && fx3Ready) begin
          stateNext   = BURST;
          wordCntNext = '0;
        end
      end
      BURST: begin
        availNext = dataAvailable;
        // empty wins over everything, including a simultaneous full glitch
        ackNow    = fx3Ready && !empty_flag;
        if (ackNow) begin
          wordCntNext = wordCnt + CW'(1);
          if (wordCnt == LAST_WORD) begin
            stateNext  = GAP;
            gapCntNext = '0;
            availNext  = 1'b0;
          end
        end
      end
      GAP: begin
        if (gapCnt == LAST_GAP) stateNext = WAIT;
        else                    gapCntNext = gapCnt + GW'(1);
      end
      default: stateNext = IDLE;
    endcase
    // Dropping capture abandons the burst; ack is cut in the same cycle
    if (!collectData) begin
      stateNext = IDLE;
      ackNow    = 1'b0;
      availNext = 1'b0;
    end
  end

  assign fifoAck = ackNow;

  // One-register output pipeline plus sticky error flags
  always_ff @(posedge outputClock or negedge nReset) begin
    if (!nReset) begin
      wordCnt        <= '0;
      gapCnt         <= '0;
      dataOut        <= '0;
      dataValid      <= 1'b0;
      dataAvailable  <= 1'b0;
      overflowError  <= 1'b0;
      underflowError <= 1'b0;
    end else begin
      wordCnt       <= wordCntNext;
      gapCnt        <= gapCntNext;
      dataAvailable <= availNext;
      dataValid     <= ackNow;
      if (ackNow)            dataOut <= fifoData;
      else if (!collectData) dataOut <= '0;
      if (!collectData) begin
        overflowError  <= 1'b0;
        underflowError <= 1'b0;
      end else begin
        if (full_flag && state != IDLE)
          overflowError <= 1'b1;
        if (state == BURST && fx3Ready && empty_flag)
          underflowError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fx3_burst_reader.sv
// tb_fx3_burst_reader
//   Directed bench for fx3_burst_reader with BURST_WORDS=4096, GAP_CYCLES=4.
//   The FIFO model serves an incrementing word per acknowledge. A monitor
//   checks the output stream against the expected running word index.
//   It also tracks run lengths of dataValid and of low dataAvailable.
module tb_fx3_burst_reader;

  localparam int BW  = 4096;
  localparam int GAP = 4;

  logic        outputClock;
  logic        nReset;
  logic        collectData;
  logic [15:0] fifoData;
  logic        emptyFlag, halfFullFlag, fullFlag;
  logic        fifoAck;
  logic        fx3Ready;
  logic [15:0] dataOut;
  logic        dataValid, dataAvailable, overflowError, underflowError;

  fx3_burst_reader #(.BURST_WORDS(BW), .GAP_CYCLES(GAP)) dut (
    .outputClock   (outputClock),
    .nReset        (nReset),
    .collectData   (collectData),
    .fifoData      (fifoData),
    .empty_flag    (emptyFlag),
    .halfFull_flag (halfFullFlag),
    .full_flag     (fullFlag),
    .fifoAck       (fifoAck),
    .fx3Ready      (fx3Ready),
    .dataOut       (dataOut),
    .dataValid     (dataValid),
    .dataAvailable (dataAvailable),
    .overflowError (overflowError),
    .underflowError(underflowError)
  );

  initial begin
    outputClock = 1'b0;
    forever #5 outputClock = ~outputClock;
  end

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // FIFO model: word index advances on each acknowledged edge
  int ackTotal = 0;
  int ackBase  = 0;
  always @(posedge outputClock) if (fifoAck) ackTotal <= ackTotal + 1;
  assign fifoData = 16'(ackTotal - ackBase);

  // Output monitor, sampled mid-low-phase after inputs have settled
  int validTotal = 0;
  int validBase  = 0;
  int wordErr    = 0;
  int vldRun     = 0;
  int lastRun    = 0;
  int daLow      = 0;
  int lastDaLow  = 0;
  int ackOnEmpty = 0;
  always @(negedge outputClock) begin
    #2;
    if (fifoAck && emptyFlag) ackOnEmpty++;
    if (dataValid) begin
      if (dataOut !== 16'(validTotal - validBase)) wordErr++;
      validTotal++;
      vldRun++;
    end else begin
      if (vldRun != 0) lastRun = vldRun;
      vldRun = 0;
    end
    if (!dataAvailable) daLow++;
    else begin
      if (daLow != 0) lastDaLow = daLow;
      daLow = 0;
    end
  end

  task automatic tick();
    @(negedge outputClock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setBase();
    ackBase   = ackTotal;
    validBase = validTotal;
  endtask

  task automatic waitWords(input string tag, input int n, input int limit);
    int k = 0;
    while ((validTotal - validBase) < n && k < limit) begin
      tick();
      k++;
    end
    if (k >= limit) chk(tag, 32'(validTotal - validBase), 32'(n));
  endtask

  task automatic waitAvail(input string tag, input int limit);
    int k = 0;
    while (!dataAvailable && k < limit) begin
      tick();
      k++;
    end
    if (k >= limit) chk(tag, 32'(dataAvailable), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errMark;
  int emptyMark;

  initial begin
    nReset = 1'b0; collectData = 1'b0; emptyFlag = 1'b0; halfFullFlag = 1'b0;
    fullFlag = 1'b0; fx3Ready = 1'b0;
    ticks(2);
    chk("rst_dataOut",   32'(dataOut), 32'd0);
    chk("rst_dataValid", 32'(dataValid), 32'd0);
    chk("rst_avail",     32'(dataAvailable), 32'd0);
    chk("rst_ack",       32'(fifoAck), 32'd0);
    chk("rst_ovf",       32'(overflowError), 32'd0);
    chk("rst_unf",       32'(underflowError), 32'd0);
    nReset = 1'b1;
    tick();

    // 1: continuous burst
    setBase();
    errMark = wordErr;
    halfFullFlag = 1'b1; fx3Ready = 1'b1; collectData = 1'b1;
    waitWords("t1_timeout", BW, 6000);
    fx3Ready = 1'b0;
    tick();
    chk("t1_acks",  32'(ackTotal - ackBase), 32'(BW));
    chk("t1_run",   32'(lastRun), 32'(BW));
    chk("t1_words", 32'(wordErr - errMark), 32'd0);
    waitAvail("t1_availTimeout", 20);
    tick();
    chk("t1_availLow", 32'(lastDaLow), 32'(GAP + 1));
    chk("t1_unf", 32'(underflowError), 32'd0);
    chk("t1_ovf", 32'(overflowError), 32'd0);

    // 2: fx3Ready toggling every 3 cycles
    setBase();
    errMark = wordErr;
    begin
      int k = 0;
      while ((validTotal - validBase) < BW && k < 12000) begin
        fx3Ready = ((k / 3) % 2) == 0;
        tick();
        k++;
      end
      if (k >= 12000) chk("t2_timeout", 32'(validTotal - validBase), 32'(BW));
    end
    fx3Ready = 1'b0;
    ticks(3);
    chk("t2_acks",  32'(ackTotal - ackBase), 32'(BW));
    chk("t2_words", 32'(wordErr - errMark), 32'd0);
    chk("t2_count", 32'(validTotal - validBase), 32'(BW));

    // 3: FIFO runs empty for 5 cycles mid-burst
    setBase();
    errMark = wordErr;
    fx3Ready = 1'b1;
    waitWords("t3_timeout1", 2000, 3000);
    emptyMark = ackOnEmpty;
    emptyFlag = 1'b1;
    ticks(3);
    chk("t3_ackStall", 32'(fifoAck), 32'd0);
    chk("t3_vldStall", 32'(dataValid), 32'd0);
    ticks(2);
    emptyFlag = 1'b0;
    tick();
    chk("t3_unfSet",   32'(underflowError), 32'd1);
    chk("t3_ackEmpty", 32'(ackOnEmpty - emptyMark), 32'd0);
    waitWords("t3_timeout2", BW, 3000);
    fx3Ready = 1'b0;
    ticks(3);
    chk("t3_acks",    32'(ackTotal - ackBase), 32'(BW));
    chk("t3_words",   32'(wordErr - errMark), 32'd0);
    chk("t3_unfHeld", 32'(underflowError), 32'd1);

    // 4: full pulse while waiting
    waitAvail("t4_availTimeout", 20);
    chk("t4_ovfBefore", 32'(overflowError), 32'd0);
    fullFlag = 1'b1;
    tick();
    fullFlag = 1'b0;
    chk("t4_ovfSet", 32'(overflowError), 32'd1);
    ticks(3);
    chk("t4_ovfHeld", 32'(overflowError), 32'd1);
    collectData = 1'b0;
    tick();
    chk("t4_ovfClr", 32'(overflowError), 32'd0);
    chk("t4_unfClr", 32'(underflowError), 32'd0);
    chk("t4_avail",  32'(dataAvailable), 32'd0);

    // 5: drop capture at word 1000, then restart
    setBase();
    errMark = wordErr;
    collectData = 1'b1; fx3Ready = 1'b1;
    waitWords("t5_timeout1", 1000, 2000);
    chk("t5_ackBefore", 32'(fifoAck), 32'd1);
    collectData = 1'b0;
    #1;
    chk("t5_ackCut", 32'(fifoAck), 32'd0);
    tick();
    chk("t5_vld",     32'(dataValid), 32'd0);
    chk("t5_avail",   32'(dataAvailable), 32'd0);
    chk("t5_ack",     32'(fifoAck), 32'd0);
    chk("t5_dataOut", 32'(dataOut), 32'd0);
    chk("t5_words1",  32'(wordErr - errMark), 32'd0);
    setBase();
    errMark = wordErr;
    collectData = 1'b1;
    waitWords("t5_timeout2", BW, 6000);
    fx3Ready = 1'b0;
    ticks(3);
    chk("t5_acks",  32'(ackTotal - ackBase), 32'(BW));
    chk("t5_run",   32'(lastRun), 32'(BW));
    chk("t5_words", 32'(wordErr - errMark), 32'd0);

    // 6: asynchronous reset mid-burst
    setBase();
    errMark = wordErr;
    fx3Ready = 1'b1;
    waitWords("t6_timeout", 500, 2000);
    chk("t6_words", 32'(wordErr - errMark), 32'd0);
    @(posedge outputClock);
    #2;
    nReset = 1'b0;
    #1;
    chk("t6_dataOut", 32'(dataOut), 32'd0);
    chk("t6_vld",     32'(dataValid), 32'd0);
    chk("t6_avail",   32'(dataAvailable), 32'd0);
    chk("t6_ack",     32'(fifoAck), 32'd0);
    tick();
    collectData = 1'b0; halfFullFlag = 1'b0; fx3Ready = 1'b0;
    nReset = 1'b1;
    ticks(3);
    chk("t6_availIdle", 32'(dataAvailable), 32'd0);
    collectData = 1'b1;
    ticks(3);
    chk("t6_availNoHalf", 32'(dataAvailable), 32'd0);
    halfFullFlag = 1'b1;
    ticks(2);
    chk("t6_availBack", 32'(dataAvailable), 32'd1);
    chk("t6_ovf", 32'(overflowError), 32'd0);
    chk("t6_unf", 32'(underflowError), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
